usb_tx_writer: RTL and testbench
================================

// Module: usb_tx_writer
// PURPOSE
//  Transmit path to the FT245-style USB FIFO chip: the write-side counterpart of the receive path.
//  Accepts bytes from internal logic (status/ack replies) on a valid/ready port and buffers them in a small FIFO.
//  Drives the chip's async write cycle (data bus, wr_n) paced by txe_n.
//  Yields the shared data bus whenever the receive side owns it (bus_free low).
// PARAMETERS
//  FIFO_AW     4  log2 of byte-FIFO depth (16 entries)
//  SETUP_CYC   2  cycles data is driven before wr_n falls (>=1)
//  PULSE_CYC   3  cycles wr_n is held low (>=1)
//  RECOV_CYC   4  cycles after bus release before the next byte may start (>=1)
// PORTS
//  clk         in   1        system clock
//  reset_n     in   1        async active-low reset
//  tx_data     in   8        byte to send
//  tx_valid    in   1        tx_data valid
//  tx_ready    out  1        FIFO can accept (= !full)
//  txe_n_raw   in   1        chip TX-space flag, async, low = chip can accept a byte
//  bus_free    in   1        high = receive path is not using data bus / rd_n
//  data_out    out  8        byte driven to the chip data bus
//  data_oe     out  1        tri-state enable for data_out (top level drives inout)
//  wr_n        out  1        write strobe to chip, active low; chip latches on rising edge
//  tx_busy     out  1        high in any state other than IDLE
//  fifo_count  out  FIFO_AW+1  bytes currently buffered
// BEHAVIOUR
//  Reset (async): wr_n=1, data_oe=0, data_out=0, tx_busy=0, fifo_count=0, state=IDLE.
//   During reset tx_ready=0. txe sync flops reset to 1 (chip not ready).
//   Reset mid-write drops wr_n/data_oe immediately and discards all buffered bytes.
//  txe_n_raw passes through a 2-flop synchronizer (txe_s); 2-cycle latency.
//  FIFO:
//   - push on tx_valid&&tx_ready.
//   - pop only on IDLE->SETUP.
//   - simultaneous push+pop leaves count unchanged.
//   - pointers wrap modulo 2**FIFO_AW; count never exceeds 2**FIFO_AW.
//   - full -> tx_ready=0, tx_valid ignored.
//  FSM:
//   IDLE:    wr_n=1, data_oe=0. Go to SETUP when fifo_count!=0 && txe_s==0 && bus_free==1.
//            On that edge: data_out<=FIFO head, data_oe<=1, pop.
//   SETUP:   SETUP_CYC cycles, wr_n=1, data held; then wr_n<=0.
//   STROBE:  PULSE_CYC cycles wr_n=0; then wr_n<=1.
//   HOLD:    1 cycle, wr_n=1, data still driven; then data_oe<=0.
//   RECOVER: RECOV_CYC cycles, bus released, txe_s and bus_free ignored; then IDLE.
//  Write cycle rules:
//   - bus_free and txe_s are sampled only in IDLE.
//   - a started write always completes even if either input changes.
//   - data_out is stable from SETUP entry through HOLD.
//   - data_oe and wr_n=0 are never asserted outside SETUP..HOLD.
//  Timing:
//   - min byte period = 1 + SETUP_CYC + PULSE_CYC + 1 + RECOV_CYC; 11 cycles at defaults.
//   - latency: byte pushed at edge E into empty FIFO, txe_s=0, bus_free=1 -> data_oe rises at E+1, wr_n falls at E+1+SETUP_CYC.
//  Ordering: bytes leave in strict acceptance order; none dropped or duplicated.
// TESTING
//  1 Push 0xA5, txe_n=0, bus_free=1:
//    data_oe rises 1 cycle later; wr_n low exactly 3 cycles; data_out=0xA5 throughout; data_oe falls 1 cycle after wr_n rises.
//  2 Push 0x01..0x05 back-to-back, txe_n=0:
//    5 wr_n pulses in order, rising edges exactly 11 cycles apart; fifo_count returns to 0.
//  3 Hold txe_n=1, push 17 bytes:
//    tx_ready=0 after 16; 17th held until a pop. Release txe_n: first wr_n falls >=2 cycles later (sync) plus SETUP_CYC.
//  4 bus_free=0 with data queued:
//    no data_oe/wr_n activity. bus_free dropping mid-STROBE: cycle still completes with unchanged timing.
//  5 Push and start a write on the same edge at count=3: count stays 3.
//    Fill to 16, push+pop together: count stays 16, tx_ready behaves correctly.
//  6 Assert reset_n=0 during STROBE:
//    wr_n=1 and data_oe=0 in the same cycle; after release fifo_count=0 and no further writes.

Source files
------------

// File: rtl/usb_tx_writer.sv
// usb_tx_writer: write side of an FT245-style USB FIFO interface.
// Bytes from internal logic are queued in a small FIFO. Each byte is then
// sent to the chip with one async write cycle (setup, strobe, hold, recovery),
// paced by the chip's txe_n flag. Nothing is driven onto the shared data bus
// while the receive path owns it.
module usb_tx_writer #(
  parameter int FIFO_AW   = 4,  // log2 of FIFO depth
  parameter int SETUP_CYC = 2,  // data driven before wr_n falls (>=1)
  parameter int PULSE_CYC = 3,  // wr_n low time (>=1)
  parameter int RECOV_CYC = 4   // idle time after bus release (>=1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [7:0]         tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  input  logic               txe_n_raw,
  input  logic               bus_free,
  output logic [7:0]         data_out,
  output logic               data_oe,
  output logic               wr_n,
  output logic               tx_busy,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam int              DEPTH_I     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH      = (FIFO_AW + 1)'(DEPTH_I);
  localparam logic [7:0]      SETUP_LAST  = 8'(SETUP_CYC - 1);
  localparam logic [7:0]      PULSE_LAST  = 8'(PULSE_CYC - 1);
  localparam logic [7:0]      RECOV_LAST  = 8'(RECOV_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RECOVER
  } state_t;

  // ---------------------------------------------------------------------------
  // txe_n synchronizer
  // ---------------------------------------------------------------------------
  logic txe_meta;
  logic txe_s;

  // Two-flop synchronizer; resets to "chip not ready" so nothing starts early.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, whatever the statement order.
    if (!reset_n) begin
      txe_meta <= 1'b1;
      txe_s    <= 1'b1;
    end else begin
      txe_meta <= txe_n_raw;
      txe_s    <= txe_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]         mem [DEPTH_I];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [7:0]         head;
  logic               full;
  logic               push;
  logic               pop;

  assign full     = (fifo_count == DEPTH);
  // Ready is held low during reset so no byte is accepted into a cleared FIFO.
  assign tx_ready = reset_n && !full;
  assign push     = tx_valid && tx_ready;
  assign head     = mem[rd_ptr];

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; validity is tracked
    // by the pointers and count, which are reset.
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at 2**FIFO_AW.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write-cycle FSM
  // ---------------------------------------------------------------------------
  state_t     state, state_d;
  logic [7:0] cnt, cnt_d;
  logic       wr_n_d;
  logic       data_oe_d;
  logic [7:0] data_out_d;

  assign tx_busy = (state != S_IDLE);

  // State and registered bus outputs; reset releases the bus immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      wr_n     <= 1'b1;
      data_oe  <= 1'b0;
      data_out <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      wr_n     <= wr_n_d;
      data_oe  <= data_oe_d;
      data_out <= data_out_d;
    end
  end

  // Next-state and next-output logic; chip flags are only looked at in IDLE,
  // so a started write always runs to completion with fixed timing.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d    = state;
    cnt_d      = cnt;
    wr_n_d     = wr_n;
    data_oe_d  = data_oe;
    data_out_d = data_out;
    pop        = 1'b0;

    case (state)
      S_IDLE: begin
        wr_n_d    = 1'b1;
        data_oe_d = 1'b0;
        if ((fifo_count != '0) && !txe_s && bus_free) begin
          state_d    = S_SETUP;
          cnt_d      = '0;
          data_out_d = head;
          data_oe_d  = 1'b1;
          pop        = 1'b1;
        end
      end

      S_SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_d = S_STROBE;
          cnt_d   = '0;
          wr_n_d  = 1'b0;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end

      S_STROBE: begin
        if (cnt == PULSE_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          wr_n_d  = 1'b1;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end

      S_HOLD: begin
        state_d   = S_RECOVER;
        cnt_d     = '0;
        data_oe_d = 1'b0;
      end

      S_RECOVER: begin
        if (cnt == RECOV_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end

      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        wr_n_d    = 1'b1;
        data_oe_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_usb_tx_writer.sv
// tb_usb_tx_writer: self-checking bench for usb_tx_writer.
// A table of single-byte vectors covers the txe_n/bus_free gating; hand-written
// sequences cover timing, full FIFO, simultaneous push/pop and mid-write reset.
// Bytes are queued as expected when accepted and compared while driven.
module tb_usb_tx_writer;

  localparam int FIFO_AW   = 4;
  localparam int SETUP_CYC = 2;
  localparam int PULSE_CYC = 3;
  localparam int RECOV_CYC = 4;
  localparam int PERIOD    = 1 + SETUP_CYC + PULSE_CYC + 1 + RECOV_CYC;

  logic             clk;
  logic             reset_n;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             txe_n_raw;
  logic             bus_free;
  logic [7:0]       data_out;
  logic             data_oe;
  logic             wr_n;
  logic             tx_busy;
  logic [FIFO_AW:0] fifo_count;

  usb_tx_writer #(
    .FIFO_AW  (FIFO_AW),
    .SETUP_CYC(SETUP_CYC),
    .PULSE_CYC(PULSE_CYC),
    .RECOV_CYC(RECOV_CYC)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .txe_n_raw (txe_n_raw),
    .bus_free  (bus_free),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .wr_n      (wr_n),
    .tx_busy   (tx_busy),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Scoreboard and monitor state
  logic [7:0] exp_q[$];
  int         rise_q[$];
  int         cyc = 0;
  int         oe_seen = 0;
  bit         mon_en = 0;
  logic       prev_wr = 1'b1;
  logic       prev_oe = 1'b0;
  int         oe_rise_cyc = 0;
  int         fall_cyc = 0;
  int         rise_cyc = 0;

  typedef struct {
    logic [7:0] data;
    logic       txe_n;
    logic       bus_free;
    int         exp_writes;
    int         exp_count;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Observes the write bus once per cycle and compares it with the scoreboard.
  task automatic monitor();
    if (mon_en) begin
      if (!data_oe) check("no_strobe_without_oe", 32'(wr_n), 32'd1);
      if (data_oe) begin
        if (exp_q.size() == 0) check("unexpected_write", 32'(data_out), 32'hFFFF_FFFF);
        else                   check("data_out", 32'(data_out), 32'(exp_q[0]));
      end
      if (!prev_oe && data_oe) begin
        oe_rise_cyc = cyc;
        oe_seen++;
      end
      if (prev_wr && !wr_n) begin
        fall_cyc = cyc;
        check("setup_len", 32'(cyc - oe_rise_cyc), 32'(SETUP_CYC));
      end
      if (!prev_wr && wr_n) begin
        rise_cyc = cyc;
        check("pulse_len", 32'(cyc - fall_cyc), 32'(PULSE_CYC));
        rise_q.push_back(cyc);
      end
      if (prev_oe && !data_oe) begin
        check("hold_len", 32'(cyc - rise_cyc), 32'd1);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    prev_wr = wr_n;
    prev_oe = data_oe;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Offers one byte, waiting (bounded) for tx_ready; returns one cycle after acceptance.
  task automatic push_byte(input logic [7:0] d, input int budget);
    int n;
    n = 0;
    tx_valid = 1'b1;
    tx_data  = d;
    while (!tx_ready && n < budget) begin
      tick();
      n++;
    end
    if (!tx_ready) begin
      check("push_timeout", 32'd0, 32'd1);
      tx_valid = 1'b0;
      return;
    end
    exp_q.push_back(d);
    tick();
    tx_valid = 1'b0;
  endtask

  // Opens the path and waits (bounded) until every queued byte has been written.
  task automatic drain(input int budget);
    int n;
    n = 0;
    txe_n_raw = 1'b0;
    bus_free  = 1'b1;
    tick();
    while (!(fifo_count == 0 && !tx_busy) && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", 32'(fifo_count == 0 && !tx_busy), 32'd1);
  endtask

  task automatic wait_wr_low(input int budget);
    int n;
    n = 0;
    while (wr_n && n < budget) begin
      tick();
      n++;
    end
    check("wr_low_seen", 32'(wr_n), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int k_fall;

    vecs[0] = '{8'h3C, 1'b0, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 0, 1};
    vecs[2] = '{8'hFF, 1'b0, 1'b0, 0, 1};
    vecs[3] = '{8'h81, 1'b1, 1'b0, 0, 1};
    vecs[4] = '{8'h5A, 1'b0, 1'b1, 1, 0};

    reset_n   = 1'b0;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    txe_n_raw = 1'b1;
    bus_free  = 1'b1;

    // Reset state
    ticks(2);
    check("rst_wr_n", 32'(wr_n), 32'd1);
    check("rst_data_oe", 32'(data_oe), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    reset_n = 1'b1;
    tick();
    check("post_rst_tx_ready", 32'(tx_ready), 32'd1);
    mon_en = 1;

    // Table: one byte under each txe_n/bus_free combination
    for (int i = 0; i < 5; i++) begin
      txe_n_raw = vecs[i].txe_n;
      bus_free  = vecs[i].bus_free;
      ticks(3);
      w0 = oe_seen;
      push_byte(vecs[i].data, 4);
      ticks(14);
      check("vec_writes", 32'(oe_seen - w0), 32'(vecs[i].exp_writes));
      check("vec_count", 32'(fifo_count), 32'(vecs[i].exp_count));
      check("vec_busy", 32'(tx_busy), 32'd0);
      drain(40);
    end

    // Single byte latency and shape
    push_byte(8'hA5, 4);
    check("t1_count_after_push", 32'(fifo_count), 32'd1);
    check("t1_oe_before", 32'(data_oe), 32'd0);
    tick();
    check("t1_oe_rise", 32'(data_oe), 32'd1);
    check("t1_data", 32'(data_out), 32'hA5);
    check("t1_busy", 32'(tx_busy), 32'd1);
    check("t1_count_popped", 32'(fifo_count), 32'd0);
    tick();
    check("t1_wr_setup", 32'(wr_n), 32'd1);
    tick();
    check("t1_wr_fall", 32'(wr_n), 32'd0);
    drain(40);

    // Back-to-back bytes: strict order, 11-cycle spacing
    rise_q.delete();
    for (int i = 1; i <= 5; i++) push_byte(8'(i), 4);
    drain(100);
    check("t2_pulses", 32'(rise_q.size()), 32'd5);
    for (int i = 1; i < rise_q.size(); i++)
      check("t2_period", 32'(rise_q[i] - rise_q[i-1]), 32'(PERIOD));

    // Fill to full with the chip blocked, then release
    txe_n_raw = 1'b1;
    ticks(3);
    for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i), 2);
    check("t3_full_count", 32'(fifo_count), 32'd16);
    check("t3_full_ready", 32'(tx_ready), 32'd0);
    tx_valid = 1'b1;
    tx_data  = 8'hEE;
    ticks(3);
    check("t3_17th_ignored", 32'(fifo_count), 32'd16);
    txe_n_raw = 1'b0;
    k_fall = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 2) check("t3_still_full", 32'(fifo_count), 32'd16);
      if (k == 3) begin
        check("t3_pop_count", 32'(fifo_count), 32'd15);
        check("t3_pop_ready", 32'(tx_ready), 32'd1);
        check("t3_pop_oe", 32'(data_oe), 32'd1);
        exp_q.push_back(8'hEE);
      end
      if (k == 4) begin
        check("t3_refill_count", 32'(fifo_count), 32'd16);
        check("t3_refill_ready", 32'(tx_ready), 32'd0);
        tx_valid = 1'b0;
      end
      if (!wr_n && k_fall == 0) k_fall = k;
    end
    check("t3_first_wr_fall", 32'(k_fall), 32'(2 + 1 + SETUP_CYC));
    drain(17 * PERIOD + 40);

    // bus_free dropping mid-strobe does not disturb the cycle
    push_byte(8'h77, 4);
    wait_wr_low(10);
    bus_free = 1'b0;
    ticks(PERIOD);
    check("t4_done_count", 32'(fifo_count), 32'd0);
    check("t4_done_busy", 32'(tx_busy), 32'd0);
    w0 = oe_seen;
    push_byte(8'h88, 4);
    push_byte(8'h99, 4);
    ticks(20);
    check("t4_blocked_writes", 32'(oe_seen - w0), 32'd0);
    check("t4_blocked_count", 32'(fifo_count), 32'd2);
    drain(60);

    // Push on the same edge a write starts, at count 3
    txe_n_raw = 1'b1;
    ticks(3);
    for (int i = 0; i < 3; i++) push_byte(8'h30 + 8'(i), 2);
    check("t5_count3", 32'(fifo_count), 32'd3);
    txe_n_raw = 1'b0;
    ticks(2);
    check("t5_pre_count", 32'(fifo_count), 32'd3);
    check("t5_pre_oe", 32'(data_oe), 32'd0);
    tx_valid = 1'b1;
    tx_data  = 8'h33;
    if (tx_ready) exp_q.push_back(8'h33);
    tick();
    tx_valid = 1'b0;
    check("t5_pushpop_count", 32'(fifo_count), 32'd3);
    check("t5_pushpop_oe", 32'(data_oe), 32'd1);
    drain(6 * PERIOD);

    // Reset during the strobe
    push_byte(8'hC3, 4);
    push_byte(8'hC4, 4);
    wait_wr_low(10);
    mon_en  = 0;
    reset_n = 1'b0;
    #1;
    check("t6_wr_n", 32'(wr_n), 32'd1);
    check("t6_oe", 32'(data_oe), 32'd0);
    check("t6_count", 32'(fifo_count), 32'd0);
    check("t6_ready", 32'(tx_ready), 32'd0);
    exp_q.delete();
    ticks(2);
    reset_n = 1'b1;
    tick();
    mon_en = 1;
    w0 = oe_seen;
    ticks(20);
    check("t6_no_writes", 32'(oe_seen - w0), 32'd0);
    check("t6_count_after", 32'(fifo_count), 32'd0);
    check("t6_wr_n_after", 32'(wr_n), 32'd1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
